// File: rtl/decum_8bit_pkg.sv
// Shared definitions for the decum_8bit down-counter: state encoding and default width.
package decum_8bit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : decum_8bit_pkg

// File: rtl/decum_8bit_ctrl.sv
// Control FSM for decum_8bit: load handshake, pause/run sequencing and done pulse.
module decum_8bit_ctrl
    import decum_8bit_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load_valid,
    input  logic load_zero,
    input  logic pause,
    input  logic dec_en,
    input  logic dout_is_one,
    output logic load_ready,
    output logic busy,
    output logic done,
    output logic load_accept_c,
    output logic dec_c,
    output logic term_c
);

    state_t state;
    state_t next_state;
    logic   done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            done       <= done_d;
            load_ready <= (next_state == IDLE) || (next_state == DONE);
            busy       <= (next_state == RUN) || (next_state == HOLD);
        end
    end

    // clear overrides everything; loads are only possible from IDLE/DONE,
    // pause only matters in RUN, so the per-state case encodes the priority.
    always_comb begin
        next_state    = state;
        done_d        = 1'b0;
        load_accept_c = 1'b0;
        dec_c         = 1'b0;
        term_c        = 1'b0;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_valid) begin
                        load_accept_c = 1'b1;
                        if (load_zero) begin
                            next_state = DONE;
                            done_d     = 1'b1;
                        end else begin
                            next_state = RUN;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        next_state = HOLD;
                    end else if (dec_en) begin
                        dec_c = 1'b1;
                        if (dout_is_one) begin
                            term_c     = 1'b1;
                            done_d     = 1'b1;
                            next_state = AUTO_RELOAD ? RUN : DONE;
                        end
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        next_state = RUN;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule : decum_8bit_ctrl

// File: rtl/decum_8bit.sv
// Loadable down-counter with valid/ready load, pause, done pulse and optional auto-reload.
module decum_8bit
    import decum_8bit_pkg::*;
#(
    parameter int unsigned WIDTH       = DEFAULT_WIDTH,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             dec_en,
    input  logic             pause,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] reload;
    logic             load_accept_c;
    logic             dec_c;
    logic             term_c;
    logic             load_zero_c;
    logic             dout_is_one_c;

    assign load_zero_c   = (load_data == '0);
    assign dout_is_one_c = (dout == WIDTH'(1));

    decum_8bit_ctrl #(
        .AUTO_RELOAD(AUTO_RELOAD)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .load_valid   (load_valid),
        .load_zero    (load_zero_c),
        .pause        (pause),
        .dec_en       (dec_en),
        .dout_is_one  (dout_is_one_c),
        .load_ready   (load_ready),
        .busy         (busy),
        .done         (done),
        .load_accept_c(load_accept_c),
        .dec_c        (dec_c),
        .term_c       (term_c)
    );

    // Count and reload registers; the reload value survives clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= '0;
            reload <= '0;
        end else if (clear) begin
            dout <= '0;
        end else if (load_accept_c) begin
            dout   <= load_data;
            reload <= load_data;
        end else if (term_c) begin
            dout <= AUTO_RELOAD ? reload : '0;
        end else if (dec_c) begin
            dout <= dout - WIDTH'(1);
        end
    end

endmodule : decum_8bit

// File: tb/tb_decum_8bit.sv
// Directed self-checking bench for decum_8bit, one-shot and auto-reload instances.
module tb_decum_8bit;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       pause;
    logic       dec_en;
    logic [7:0] load_data;
    logic       lv0;
    logic       lv1;

    logic       lr0, busy0, done0;
    logic [7:0] dout0;
    logic       lr1, busy1, done1;
    logic [7:0] dout1;

    int n_checks;
    int n_errors;

    decum_8bit #(.WIDTH(8), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .load_valid(lv0), .load_data(load_data),
        .load_ready(lr0), .dec_en(dec_en), .pause(pause), .dout(dout0),
        .busy(busy0), .done(done0)
    );

    decum_8bit #(.WIDTH(8), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .load_valid(lv1), .load_data(load_data),
        .load_ready(lr1), .dec_en(dec_en), .pause(pause), .dout(dout1),
        .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dut0(input string tag, input logic [7:0] d, input logic b,
                              input logic lr, input logic dn);
        check_eq({tag, " dout"}, 32'(dout0), 32'(d));
        check_eq({tag, " busy"}, 32'(busy0), 32'(b));
        check_eq({tag, " load_ready"}, 32'(lr0), 32'(lr));
        check_eq({tag, " done"}, 32'(done0), 32'(dn));
    endtask

    initial begin
        logic [7:0] exp_seq [0:3];
        logic [7:0] auto_seq [0:5];
        logic       auto_done [0:5];

        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        pause     = 1'b0;
        dec_en    = 1'b0;
        load_data = 8'd0;
        lv0       = 1'b0;
        lv1       = 1'b0;

        // Reset state
        tick();
        tick();
        check_dut0("reset", 8'd0, 1'b0, 1'b1, 1'b0);
        check_eq("reset dut1 load_ready", 32'(lr1), 32'd1);
        rst = 1'b0;
        tick();

        // Load 3 with dec_en held: 3,2,1,0 then DONE
        exp_seq = '{8'd3, 8'd2, 8'd1, 8'd0};
        load_data = 8'd3;
        lv0       = 1'b1;
        dec_en    = 1'b1;
        tick();
        lv0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) check_dut0($sformatf("cnt3[%0d]", i), exp_seq[i], 1'b1, 1'b0, 1'b0);
            else       check_dut0($sformatf("cnt3[%0d]", i), exp_seq[i], 1'b0, 1'b1, 1'b1);
            if (i < 3) tick();
        end
        tick();
        check_dut0("cnt3 after", 8'd0, 1'b0, 1'b1, 1'b0);

        // Load 5, pause three cycles once dout reaches 4
        load_data = 8'd5;
        lv0       = 1'b1;
        tick();
        lv0 = 1'b0;
        check_dut0("p5 load", 8'd5, 1'b1, 1'b0, 1'b0);
        tick();
        check_dut0("p5 at4", 8'd4, 1'b1, 1'b0, 1'b0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_dut0($sformatf("p5 hold[%0d]", i), 8'd4, 1'b1, 1'b0, 1'b0);
        end
        pause = 1'b0;
        tick();
        check_dut0("p5 resume", 8'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 1; i--) begin
            tick();
            check_dut0($sformatf("p5 cnt%0d", i), 8'(i), 1'b1, 1'b0, 1'b0);
        end
        tick();
        check_dut0("p5 zero", 8'd0, 1'b0, 1'b1, 1'b1);
        tick();
        check_dut0("p5 after", 8'd0, 1'b0, 1'b1, 1'b0);

        // Load 0: immediate done, never busy; then load 7 during the done pulse
        dec_en    = 1'b0;
        load_data = 8'd0;
        lv0       = 1'b1;
        tick();
        lv0 = 1'b0;
        check_dut0("z0 load", 8'd0, 1'b0, 1'b1, 1'b1);
        load_data = 8'd7;
        lv0       = 1'b1;
        tick();
        lv0 = 1'b0;
        check_dut0("done->load7", 8'd7, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_dut0("clear7", 8'd0, 1'b0, 1'b1, 1'b0);

        // Load 200, ten decrements, synchronous clear
        dec_en    = 1'b1;
        load_data = 8'd200;
        lv0       = 1'b1;
        tick();
        lv0 = 1'b0;
        repeat (10) tick();
        check_dut0("c200 count", 8'd190, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_dut0("c200 clear", 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        check_dut0("c200 idle", 8'd0, 1'b0, 1'b1, 1'b0);

        // Same run with async reset mid-count, checked before the next edge
        lv0 = 1'b1;
        tick();
        lv0 = 1'b0;
        repeat (10) tick();
        check_dut0("r200 count", 8'd190, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_dut0("r200 async", 8'd0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        tick();

        // Async reset drops a done pulse in flight
        load_data = 8'd1;
        lv0       = 1'b1;
        tick();
        lv0 = 1'b0;
        tick();
        check_dut0("r1 done", 8'd0, 1'b0, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("r1 done dropped", 32'(done0), 32'd0);
        rst = 1'b0;
        tick();

        // Auto-reload with value 2; a load offered mid-run must be ignored
        auto_seq  = '{8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1};
        auto_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        load_data = 8'd2;
        lv1       = 1'b1;
        tick();
        lv1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("auto dout[%0d]", i), 32'(dout1), 32'(auto_seq[i]));
            check_eq($sformatf("auto done[%0d]", i), 32'(done1), 32'(auto_done[i]));
            check_eq($sformatf("auto busy[%0d]", i), 32'(busy1), 32'd1);
            check_eq($sformatf("auto lr[%0d]", i), 32'(lr1), 32'd0);
            if (i == 2) begin
                load_data = 8'd9;
                lv1       = 1'b1;
            end else begin
                lv1 = 1'b0;
            end
            tick();
        end
        check_eq("auto dout end", 32'(dout1), 32'd2);
        check_eq("auto done end", 32'(done1), 32'd1);
        dec_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_decum_8bit
